tx_packet_scheduler: RTL

- Sits directly upstream of tx_data_encoder, between the cognitive map and the encoder's word-write interface.
- Stages up to MAX_WORDS 16-bit response words, then bursts them into the encoder as one frame.
- Sequences re-transmit header and re-transmit response requests so that no encoder operation starts while a frame is still on the UART.
- Detects frame completion by counting falling edges of the encoder's busy output.

---
 rtl/tx_packet_scheduler_if.sv | 44 ++++
 rtl/tx_packet_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_packet_scheduler_if.sv
// ---------------------------------------------------------------------------
// tx_packet_scheduler_if
//   Word-write / strobe bus between tx_packet_scheduler and tx_data_encoder.
//
//   o_Wr_Tx_Word      scheduler -> encoder  word write strobe
//   o_Tx_Word         scheduler -> encoder  16-bit word
//   o_Tx_Word_Cnt     scheduler -> encoder  words in this frame
//   o_Resp_Type       scheduler -> encoder  response type of this frame
//   o_Send_Re_Tx_Hdr  scheduler -> encoder  send 0xCE re-transmit header
//   o_Re_Tx_Response  scheduler -> encoder  resend the last frame
//   i_Tx_Busy         encoder -> scheduler  UART byte in progress
//
//   modport master : scheduler side
//   modport slave  : encoder side
// ---------------------------------------------------------------------------
interface tx_packet_scheduler_if;
    logic        o_Wr_Tx_Word;
    logic [15:0] o_Tx_Word;
    logic [3:0]  o_Tx_Word_Cnt;
    logic [3:0]  o_Resp_Type;
    logic        o_Send_Re_Tx_Hdr;
    logic        o_Re_Tx_Response;
    logic        i_Tx_Busy;

    modport master (
        output o_Wr_Tx_Word,
        output o_Tx_Word,
        output o_Tx_Word_Cnt,
        output o_Resp_Type,
        output o_Send_Re_Tx_Hdr,
        output o_Re_Tx_Response,
        input  i_Tx_Busy
    );

    modport slave (
        input  o_Wr_Tx_Word,
        input  o_Tx_Word,
        input  o_Tx_Word_Cnt,
        input  o_Resp_Type,
        input  o_Send_Re_Tx_Hdr,
        input  o_Re_Tx_Response,
        output i_Tx_Busy
    );
endinterface

// File: rtl/tx_packet_scheduler.sv
// ---------------------------------------------------------------------------
// tx_packet_scheduler
//   Stages up to MAX_WORDS response words and bursts them into the encoder as
//   one frame. Re-transmit header / response requests are queued and only
//   issued once the previous frame has left the UART, which is detected by
//   counting falling edges of the encoder busy flag, followed by a short
//   guard gap.
//
//   i_Clock, i_Reset     clock, synchronous active-high reset
//   i_Word_Wr, i_Word    stage one word per cycle
//   i_Send, i_Resp_Type  send staged words as one frame
//   i_Req_Re_Tx_Hdr      request 0xCE re-transmit header
//   i_Req_Re_Tx_Resp     request resend of the last frame
//   enc                  encoder bus (strobes out, busy in)
//   o_Ready              staging open and no send pending
//   o_Error              1-cycle pulse on a rejected request
//   o_Timeout            1-cycle pulse when a busy-edge wait is abandoned
// ---------------------------------------------------------------------------
module tx_packet_scheduler #(
    parameter int unsigned MAX_WORDS    = 3,
    parameter int unsigned TIMEOUT_CLKS = 8192,
    parameter int unsigned GUARD_CLKS   = 4
) (
    input  logic                         i_Clock,
    input  logic                         i_Reset,
    input  logic                         i_Word_Wr,
    input  logic [15:0]                  i_Word,
    input  logic                         i_Send,
    input  logic [3:0]                   i_Resp_Type,
    input  logic                         i_Req_Re_Tx_Hdr,
    input  logic                         i_Req_Re_Tx_Resp,
    tx_packet_scheduler_if.master        enc,
    output logic                         o_Ready,
    output logic                         o_Error,
    output logic                         o_Timeout
);

    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);
    localparam int unsigned IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam int unsigned GRD_W = $clog2(GUARD_CLKS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GUARD = 2'd3;

    logic [1:0]       r_state;
    logic [15:0]      r_stage [MAX_WORDS];
    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] r_idx;
    logic             r_pend_send;
    logic             r_pend_hdr;
    logic             r_pend_resp;
    logic [3:0]       r_resp_type;
    logic             r_have_last;
    logic [4:0]       r_last_bytes;
    logic [4:0]       r_expected;
    logic [4:0]       r_edge_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [GRD_W-1:0] r_guard_cnt;
    logic             r_busy_d;

    logic             w_ready;
    logic             w_word_ok;
    logic             w_send_ok;
    logic             w_fall;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_last_idx;
    logic [4:0]       w_frame_bytes;

    assign w_ready   = (r_state != S_BURST) && !r_pend_send;
    assign w_word_ok = i_Word_Wr && w_ready && (r_count < CNT_W'(MAX_WORDS));
    // A word written in the same cycle as i_Send counts towards the frame.
    assign w_send_ok = i_Send && w_ready && ((r_count != '0) || w_word_ok);
    assign w_fall    = r_busy_d & ~enc.i_Tx_Busy;
    assign w_wr_idx  = IDX_W'(r_count);
    assign w_last_idx    = IDX_W'(r_count - CNT_W'(1));
    // Encoder frame = header + type + count + 2 bytes/word.
    assign w_frame_bytes = (5'(r_count) << 1) + 5'd3;
    assign o_Ready   = w_ready;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state              <= S_IDLE;
            for (int unsigned i = 0; i < MAX_WORDS; i++) r_stage[i] <= '0;
            r_count              <= '0;
            r_idx                <= '0;
            r_pend_send          <= 1'b0;
            r_pend_hdr           <= 1'b0;
            r_pend_resp          <= 1'b0;
            r_resp_type          <= '0;
            r_have_last          <= 1'b0;
            r_last_bytes         <= '0;
            r_expected           <= '0;
            r_edge_cnt           <= '0;
            r_tmo_cnt            <= '0;
            r_guard_cnt          <= '0;
            r_busy_d             <= 1'b0;
            enc.o_Wr_Tx_Word     <= 1'b0;
            enc.o_Tx_Word        <= '0;
            enc.o_Tx_Word_Cnt    <= '0;
            enc.o_Resp_Type      <= '0;
            enc.o_Send_Re_Tx_Hdr <= 1'b0;
            enc.o_Re_Tx_Response <= 1'b0;
            o_Error              <= 1'b0;
            o_Timeout            <= 1'b0;
        end else begin
            r_busy_d             <= enc.i_Tx_Busy;
            enc.o_Wr_Tx_Word     <= 1'b0;
            enc.o_Send_Re_Tx_Hdr <= 1'b0;
            enc.o_Re_Tx_Response <= 1'b0;
            o_Timeout            <= 1'b0;
            o_Error              <= (i_Word_Wr && !w_word_ok) || (i_Send && !w_send_ok);

            if (w_word_ok) begin
                r_stage[w_wr_idx] <= i_Word;
                r_count           <= r_count + CNT_W'(1);
            end
            if (w_send_ok) begin
                r_pend_send <= 1'b1;
                r_resp_type <= i_Resp_Type;
            end
            // Set first; a clear while servicing below wins, so a repeat
            // arriving in the service cycle merges with the one being issued.
            if (i_Req_Re_Tx_Hdr)  r_pend_hdr  <= 1'b1;
            if (i_Req_Re_Tx_Resp) r_pend_resp <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (r_pend_hdr) begin
                        enc.o_Send_Re_Tx_Hdr <= 1'b1;
                        r_pend_hdr           <= 1'b0;
                        r_expected           <= 5'd1;
                        r_edge_cnt           <= '0;
                        r_tmo_cnt            <= '0;
                        r_state              <= S_WAIT;
                    end else if (r_pend_resp) begin
                        r_pend_resp <= 1'b0;
                        if (r_have_last) begin
                            enc.o_Re_Tx_Response <= 1'b1;
                            r_expected           <= r_last_bytes;
                            r_edge_cnt           <= '0;
                            r_tmo_cnt            <= '0;
                            r_state              <= S_WAIT;
                        end else begin
                            o_Error <= 1'b1;
                        end
                    end else if (r_pend_send) begin
                        r_idx   <= '0;
                        r_state <= S_BURST;
                    end
                end
                S_BURST: begin
                    enc.o_Wr_Tx_Word  <= 1'b1;
                    enc.o_Tx_Word     <= r_stage[r_idx];
                    enc.o_Tx_Word_Cnt <= 4'(r_count);
                    enc.o_Resp_Type   <= r_resp_type;
                    r_idx             <= r_idx + IDX_W'(1);
                    if (r_idx == w_last_idx) begin
                        r_expected   <= w_frame_bytes;
                        r_last_bytes <= w_frame_bytes;
                        r_have_last  <= 1'b1;
                        r_count      <= '0;
                        r_pend_send  <= 1'b0;
                        r_edge_cnt   <= '0;
                        r_tmo_cnt    <= '0;
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_fall) begin
                        r_tmo_cnt <= '0;
                        if (r_edge_cnt + 5'd1 == r_expected) begin
                            r_guard_cnt <= '0;
                            r_state     <= S_GUARD;
                        end else begin
                            r_edge_cnt <= r_edge_cnt + 5'd1;
                        end
                    end else if (r_tmo_cnt == TMO_W'(TIMEOUT_CLKS - 1)) begin
                        o_Timeout   <= 1'b1;
                        r_guard_cnt <= '0;
                        r_state     <= S_GUARD;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                S_GUARD: begin
                    if (r_guard_cnt == GRD_W'(GUARD_CLKS - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_guard_cnt <= r_guard_cnt + GRD_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
